cond_exec_stage: RTL
====================

// Module: cond_exec_stage
// PURPOSE
//  Execute-stage control register and condition unit, directly downstream of the instruction decoder.
//  Captures the decoded control bundle and cond field into a decode->execute register.
//  Evaluates the ARM condition against the architectural NZCV flag register.
//  Gates PCSrc/RegWrite/MemWrite and updates NZCV from ALU flags per FlagW (CMP: NoWrite + flag update).
// PARAMETERS
//  FLAGS_RST  4'b0000  reset value of NZCV register {N,Z,C,V}
//  COND_W     4        width of condition field (fixed 4; parameter for package consistency)
// PORTS
//  clk           in   1  single clock, rising edge
//  reset_n       in   1  asynchronous, active-low reset
//  d_valid       in   1  decode bundle valid
//  d_ready       out  1  stage can accept bundle (= ~stall)
//  d_cond        in   4  Instr[31:28]
//  d_flagw       in   2  [1]=update N,Z  [0]=update C,V
//  d_pcs         in   1  PC-write request (branch or Rd==15 write)
//  d_regw        in   1  register write request
//  d_memw        in   1  memory write request
//  d_nowrite     in   1  suppress register write (CMP)
//  d_memtoreg    in   1  passthrough
//  d_alusrc      in   1  passthrough
//  d_alucontrol  in   2  passthrough
//  alu_flags     in   4  {N,Z,C,V} from ALU, combinational on current E instruction
//  stall         in   1  hold E register; no commit this cycle
//  flush         in   1  load bubble into E register at next edge
//  e_valid       out  1  E register holds a live instruction
//  e_cond_ex     out  1  condition passed (0 when ~e_valid)
//  e_pcsrc       out  1  commit PC write
//  e_regwrite    out  1  commit register write
//  e_memwrite    out  1  commit memory write
//  e_memtoreg, e_alusrc  out  1  registered passthrough
//  e_alucontrol  out  2  registered passthrough
//  flags_q       out  4  architectural NZCV
// BEHAVIOUR
//  Reset: e_valid=0, all E bundle fields=0, flags_q=FLAGS_RST. All commit outputs=0. Asynchronous assert; synchronous-to-edge release.
//  Capture: at posedge, if flush -> e_valid<=0 (fields don't care, drive 0).
//           elif ~stall -> E<=d bundle, e_valid<=d_valid. elif stall -> hold.
//  flush has priority over stall and capture. A decode bundle offered with flush=1 is consumed and dropped.
//  d_ready = ~stall (combinational).
//  Condition (combinational from e_cond and flags_q):
//    0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V;
//    8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V);
//    E AL 1; F reserved -> 0 (instruction acts as NOP).
//  commit = e_valid & e_cond_ex & ~stall.
//  e_pcsrc = commit & pcs.  e_regwrite = commit & regw & ~nowrite.  e_memwrite = commit & memw.
//  Commit outputs are zero-latency from E register state; at most one commit cycle per instruction.
//  Flags: at posedge with commit:
//    flagw[1] -> flags_q[3:2]<=alu_flags[3:2]; flagw[0] -> flags_q[1:0]<=alu_flags[1:0].
//  Failed condition, bubble or stall -> no flag update.
//  Back-to-back flag setter then consumer: consumer sees updated flags_q in its E cycle (1-cycle latency; no forwarding).
//  Commit is evaluated on current E contents; the flush bubble appears next cycle.
//  A committing instruction in E with flush=1 still commits that cycle.
//  stall=1 & flush=1: current E instruction is discarded with no commit and no flag update.
//  Reset mid-operation: E contents and flags lost; no commit on the reset cycle.
// STRUCTURE
//  Package cond_pkg:
//    cond_e enum (EQ..AL, NV=4'hF); flag index localparams N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
//    ALU control constants ALU_ADD/SUB/AND/ORR; ex_ctrl_t packed struct for the E bundle.
//  Sub-module cond_check (combinational: cond, flags -> cond_ex); rest is in the top level.
// TESTING
//  1 CMP r0==r1 (cond E, flagw=11, nowrite=1, alu_flags=0100) -> regwrite=0, flags_q=0100 next cycle; then BEQ (cond 0, pcs=1) -> e_pcsrc=1.
//  2 flags_q=1001 (N=1,V=1): cond A GE -> cond_ex=1; cond B LT -> 0; cond C GT -> 1; cond D LE -> 0.
//  3 ADD with flagw=01, alu_flags=1111, flags_q=0000 -> flags_q=0011 (N,Z unchanged).
//  4 STR in E, stall=1 for 3 cycles -> e_memwrite=0 during stall, exactly one cycle of 1 after release.
//  5 stall=1 & flush=1 with valid STR in E -> no e_memwrite ever, e_valid=0 next cycle, flags unchanged.
//  6 reset_n low mid-commit -> all outputs 0 immediately, flags_q=FLAGS_RST; cond 4'hF instruction -> no commit.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types and constants for the execute-stage condition logic.
package cond_pkg;

    localparam int COND_W = 4;

    // ARM condition codes; NV (4'hF) is reserved and never passes.
    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Control bundle held in the decode->execute register.
    typedef struct packed {
        cond_e       cond;
        logic [1:0]  flagw;
        logic        pcs;
        logic        regw;
        logic        memw;
        logic        nowrite;
        logic        memtoreg;
        logic        alusrc;
        logic [1:0]  alucontrol;
    } ex_ctrl_t;

endpackage

// File: rtl/cond_exec_stage_if.sv
// Decode-side and execute-side signal bundle of the execute control stage.
interface cond_exec_stage_if;
    import cond_pkg::*;

    logic              d_valid;
    logic              d_ready;
    logic [COND_W-1:0] d_cond;
    logic [1:0]        d_flagw;
    logic              d_pcs;
    logic              d_regw;
    logic              d_memw;
    logic              d_nowrite;
    logic              d_memtoreg;
    logic              d_alusrc;
    logic [1:0]        d_alucontrol;
    logic [3:0]        alu_flags;
    logic              stall;
    logic              flush;
    logic              e_valid;
    logic              e_cond_ex;
    logic              e_pcsrc;
    logic              e_regwrite;
    logic              e_memwrite;
    logic              e_memtoreg;
    logic              e_alusrc;
    logic [1:0]        e_alucontrol;
    logic [3:0]        flags_q;

    // Pipeline/control side: drives the decode bundle and hazard controls.
    modport master (
        output d_valid, d_cond, d_flagw, d_pcs, d_regw, d_memw, d_nowrite,
               d_memtoreg, d_alusrc, d_alucontrol, alu_flags, stall, flush,
        input  d_ready, e_valid, e_cond_ex, e_pcsrc, e_regwrite, e_memwrite,
               e_memtoreg, e_alusrc, e_alucontrol, flags_q
    );

    // Execute stage itself.
    modport slave (
        input  d_valid, d_cond, d_flagw, d_pcs, d_regw, d_memw, d_nowrite,
               d_memtoreg, d_alusrc, d_alucontrol, alu_flags, stall, flush,
        output d_ready, e_valid, e_cond_ex, e_pcsrc, e_regwrite, e_memwrite,
               e_memtoreg, e_alusrc, e_alucontrol, flags_q
    );

endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation against an {N,Z,C,V} flag vector.
module cond_check
    import cond_pkg::*;
#(
    parameter int COND_W = 4
) (
    input  logic [COND_W-1:0] cond,
    input  logic [3:0]        flags,
    output logic              cond_ex
);

    cond_e cond_code;
    logic  n, z, c, v;

    assign cond_code = cond_e'(cond);
    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    // Decode the condition field into a pass/fail decision.
    always_comb begin
        cond_ex = 1'b0;
        case (cond_code)
            EQ:      cond_ex = z;
            NE:      cond_ex = ~z;
            CS:      cond_ex = c;
            CC:      cond_ex = ~c;
            MI:      cond_ex = n;
            PL:      cond_ex = ~n;
            VS:      cond_ex = v;
            VC:      cond_ex = ~v;
            HI:      cond_ex = c & ~z;
            LS:      cond_ex = ~c | z;
            GE:      cond_ex = (n == v);
            LT:      cond_ex = (n != v);
            GT:      cond_ex = ~z & (n == v);
            LE:      cond_ex = z | (n != v);
            AL:      cond_ex = 1'b1;
            default: cond_ex = 1'b0;   // NV: treated as a NOP
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage control register, condition gating and NZCV flag register.
module cond_exec_stage
    import cond_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000,
    parameter int         COND_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    cond_exec_stage_if.slave   bus
);

    ex_ctrl_t          d_bundle;
    ex_ctrl_t          e_reg;
    logic              e_valid_reg;
    logic [3:0]        flags_reg;
    logic [COND_W-1:0] e_cond_bits;
    logic              cond_pass;
    logic              commit;

    // Pack the decoder outputs into the E-register layout.
    always_comb begin
        d_bundle            = '0;
        d_bundle.cond       = cond_e'(bus.d_cond);
        d_bundle.flagw      = bus.d_flagw;
        d_bundle.pcs        = bus.d_pcs;
        d_bundle.regw       = bus.d_regw;
        d_bundle.memw       = bus.d_memw;
        d_bundle.nowrite    = bus.d_nowrite;
        d_bundle.memtoreg   = bus.d_memtoreg;
        d_bundle.alusrc     = bus.d_alusrc;
        d_bundle.alucontrol = bus.d_alucontrol;
    end

    // Decode->execute register: flush beats stall, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_reg       <= '0;
            e_valid_reg <= 1'b0;
        end else if (bus.flush) begin
            e_reg       <= '0;
            e_valid_reg <= 1'b0;
        end else if (!bus.stall) begin
            e_reg       <= d_bundle;
            e_valid_reg <= bus.d_valid;
        end
    end

    assign e_cond_bits = e_reg.cond;

    cond_check #(
        .COND_W (COND_W)
    ) u_cond_check (
        .cond    (e_cond_bits),
        .flags   (flags_reg),
        .cond_ex (cond_pass)
    );

    // A live, passing instruction commits only in a non-stalled cycle.
    assign commit = e_valid_reg & cond_pass & ~bus.stall;

    // Architectural NZCV: N/Z and C/V pairs are written independently on commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_reg <= FLAGS_RST;
        end else if (commit) begin
            if (e_reg.flagw[1]) begin
                flags_reg[N_IDX] <= bus.alu_flags[N_IDX];
                flags_reg[Z_IDX] <= bus.alu_flags[Z_IDX];
            end
            if (e_reg.flagw[0]) begin
                flags_reg[C_IDX] <= bus.alu_flags[C_IDX];
                flags_reg[V_IDX] <= bus.alu_flags[V_IDX];
            end
        end
    end

    assign bus.d_ready      = ~bus.stall;
    assign bus.e_valid      = e_valid_reg;
    assign bus.e_cond_ex    = e_valid_reg & cond_pass;
    assign bus.e_pcsrc      = commit & e_reg.pcs;
    assign bus.e_regwrite   = commit & e_reg.regw & ~e_reg.nowrite;
    assign bus.e_memwrite   = commit & e_reg.memw;
    assign bus.e_memtoreg   = e_reg.memtoreg;
    assign bus.e_alusrc     = e_reg.alusrc;
    assign bus.e_alucontrol = e_reg.alucontrol;
    assign bus.flags_q      = flags_reg;

endmodule
